// File: rtl/branch_pred_gshare.sv
// Gshare branch direction predictor with taken-target adder and an in-flight
// FIFO of prediction snapshots used to train the table and repair history.
module branch_pred_gshare #(
    parameter int HISTORY_BITS = 8,
    parameter int IMM_WIDTH    = 12,
    parameter int INFLIGHT     = 4,
    parameter int USE_GSHARE   = 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [31:0]                   program_counter_i,
    input  logic [IMM_WIDTH-1:0]          br_imm_i,
    input  logic                          issuing_branch_i,
    output logic [31:0]                   program_counter_branched_o,
    output logic                          br_taken_o,
    output logic                          inflight_full_o,
    output logic [$clog2(INFLIGHT):0]     inflight_count_o,
    input  logic                          cond_eval_i,
    input  logic                          corr_pred_i
);

    localparam int ENTRIES = 1 << HISTORY_BITS;
    localparam int PTR_W   = $clog2(INFLIGHT);
    localparam int CNT_W   = PTR_W + 1;

    logic [1:0]              pht [ENTRIES];
    logic [HISTORY_BITS-1:0] spec_hist;

    logic [HISTORY_BITS-1:0] fifo_idx  [INFLIGHT];
    logic                    fifo_pred [INFLIGHT];
    logic [HISTORY_BITS-1:0] fifo_hist [INFLIGHT];
    logic [PTR_W-1:0]        head_ptr;
    logic [PTR_W-1:0]        tail_ptr;
    logic [CNT_W-1:0]        count;

    logic [HISTORY_BITS-1:0] idx;
    logic [31:0]             br_offset;
    logic                    resolve_v;
    logic                    actual;
    logic                    mispredict;
    logic                    issue_acc;
    logic [HISTORY_BITS-1:0] head_idx;

    always_comb begin
        idx = spec_hist;
        if (USE_GSHARE != 0) begin
            idx = spec_hist ^ program_counter_i[HISTORY_BITS+1:2];
        end
    end

    assign br_taken_o = pht[idx][1];
    assign br_offset  = {{(30-IMM_WIDTH){br_imm_i[IMM_WIDTH-1]}}, br_imm_i, 2'b00};
    assign program_counter_branched_o = program_counter_i + br_offset;

    // Handshake: issuing_branch_i is a valid whose ready is (!inflight_full_o &&
    // !mispredict); cond_eval_i is a valid that is always taken when count > 0
    // and silently dropped when nothing is in flight.
    assign resolve_v  = cond_eval_i && (count != '0);
    assign actual     = corr_pred_i ? fifo_pred[head_ptr] : ~fifo_pred[head_ptr];
    assign mispredict = resolve_v && !corr_pred_i;
    assign issue_acc  = issuing_branch_i && !inflight_full_o && !mispredict;
    assign head_idx   = fifo_idx[head_ptr];

    assign inflight_count_o = count;
    assign inflight_full_o  = (count == CNT_W'(INFLIGHT));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= 2'b01;
            end
            spec_hist <= '0;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            count     <= '0;
        end else begin
            // Training reads the pre-write counter; new value is seen next cycle.
            if (resolve_v) begin
                if (actual && pht[head_idx] != 2'b11) begin
                    pht[head_idx] <= pht[head_idx] + 2'd1;
                end else if (!actual && pht[head_idx] != 2'b00) begin
                    pht[head_idx] <= pht[head_idx] - 2'd1;
                end
            end

            if (mispredict) begin
                // Rebuild history from the snapshot taken when the branch issued.
                spec_hist <= {fifo_hist[head_ptr][HISTORY_BITS-2:0], actual};
                head_ptr  <= '0;
                tail_ptr  <= '0;
                count     <= '0;
            end else begin
                if (issue_acc) begin
                    fifo_idx[tail_ptr]  <= idx;
                    fifo_pred[tail_ptr] <= br_taken_o;
                    fifo_hist[tail_ptr] <= spec_hist;
                    tail_ptr            <= tail_ptr + PTR_W'(1);
                    spec_hist           <= {spec_hist[HISTORY_BITS-2:0], br_taken_o};
                end
                if (resolve_v) begin
                    head_ptr <= head_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(issue_acc) - CNT_W'(resolve_v);
            end
        end
    end

endmodule

// File: doc/branch_pred_gshare.md
BRANCH_PRED_GSHARE -- requirements
Module: branch_pred_gshare

Interface
REQ-001 Parameter HISTORY_BITS, default 8: global history width; the pattern table holds 2**HISTORY_BITS entries; legal range 2..12.
REQ-002 Parameter IMM_WIDTH, default 12: width of the branch immediate.
REQ-003 Parameter INFLIGHT, default 4: max unresolved branches; power of 2, at least 2.
REQ-004 Parameter USE_GSHARE, default 1: 1 = index is history XOR PC[HISTORY_BITS+1:2]; 0 = index is history only.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 The ports SHALL be as follows:
- clk_i  in  1  system clock, all state on rising edge
- reset_i  in  1  synchronous active-high reset
- program_counter_i  in  32  PC of instruction being fetched
- br_imm_i  in  IMM_WIDTH  branch immediate (word offset)
- issuing_branch_i  in  1  fetch pushes a branch to the instr queue this cycle
- program_counter_branched_o  out  32  taken-path target
- br_taken_o  out  1  prediction (1 = taken)
- inflight_full_o  out  1  INFLIGHT branches unresolved; issue not accepted
- inflight_count_o  out  $clog2(INFLIGHT)+1  number of unresolved branches
- cond_eval_i  in  1  branch ALU resolved the oldest in-flight branch
- corr_pred_i  in  1  qualifies cond_eval_i; 1 = prediction correct

Function
REQ-007 Pattern table: 2**HISTORY_BITS two-bit saturating counters; prediction = counter MSB.
REQ-008 idx = spec_hist XOR PC[HISTORY_BITS+1:2] when USE_GSHARE=1, else spec_hist; combinational.
REQ-009 br_taken_o = table[idx][1], combinational from current state and program_counter_i.
REQ-010 program_counter_branched_o = program_counter_i + sign-extend_32({br_imm_i, 2'b00}), modulo 2**32, combinational.
REQ-011 Issue accepted iff issuing_branch_i=1, inflight_full_o=0 and no mispredict resolve occurs in the same cycle.
REQ-012 On accepted issue: push {idx, br_taken_o, spec_hist} to the in-flight FIFO tail; spec_hist <= {spec_hist[HISTORY_BITS-2:0], br_taken_o} on the next edge.
REQ-013 Issue while full SHALL be ignored: no FIFO, history or table change.
REQ-014 Resolve: cond_eval_i=1 with count>0 pops the FIFO head; resolves are strictly in issue order.
REQ-015 cond_eval_i=1 with count=0 SHALL be ignored.
REQ-016 Actual outcome = head.pred if corr_pred_i=1, else ~head.pred.
REQ-017 On resolve, table[head.idx] increments toward 11 if actual=1 and decrements toward 00 if actual=0; it saturates at 11 and at 00.
REQ-018 Correct resolve: spec_hist is unchanged by the resolve; a same-cycle accepted issue proceeds (count unchanged).
REQ-019 Mispredict resolve: spec_hist <= {head.hist[HISTORY_BITS-2:0], actual}; all FIFO entries are flushed; count <= 0; a same-cycle issue is dropped.
REQ-020 A table write is visible to the prediction on the following cycle; a same-cycle read returns the pre-write value.
REQ-021 inflight_full_o = (count == INFLIGHT); both outputs are registered-state derived, with no combinational path from cond_eval_i.
REQ-022 FIFO head and tail pointers wrap modulo INFLIGHT.

Reset
REQ-023 Synchronous reset SHALL set all table counters to 2'b01 (weakly not-taken) and spec_hist to 0.
REQ-024 Synchronous reset SHALL set FIFO pointers to 0, inflight_count_o to 0 and inflight_full_o to 0, so that br_taken_o is 0.
REQ-025 Reset SHALL take priority over issue and resolve in the same cycle, including mid-operation with branches in flight.

Verification
REQ-026 After reset: PC=0x100, imm=12'h010 -> target 0x140, br_taken_o=0; imm=12'hFFF -> target 0x0FC.
REQ-027 USE_GSHARE=0, PC=0, issue (pred 0) then cond_eval=1, corr=0 -> table[0]=10, spec_hist=0x01, count=0.
REQ-028 INFLIGHT=4: 4 issues -> count=4, full=1; a 5th issue is ignored (spec_hist and count unchanged).
REQ-029 With 4 in flight, mispredict on the head (snapshot hist 0x00, pred 0) -> next cycle count=0, full=0, spec_hist=0x01; a same-cycle issue is dropped.
REQ-030 Saturation: counter at 11 with 3 taken resolves stays 11; counter at 00 with 3 not-taken resolves stays 00.
REQ-031 Correct resolve plus issue in the same cycle at count=2 -> count stays 2; reset asserted with count=3 -> next cycle count=0, all counters 01.
